// File: rtl/nes_cart_pkg.sv
// Shared cartridge-loader types: loader state enum, error codes, iNES constants
// and a helper that turns a header chunk count into a byte size.
package nes_cart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_TRAINER = 3'd2,
    ST_PRG     = 3'd3,
    ST_CHR     = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } ines_ld_state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MAGIC    = 3'd1;
  localparam logic [2:0] ERR_PRG_ZERO = 3'd2;
  localparam logic [2:0] ERR_PRG_BIG  = 3'd3;
  localparam logic [2:0] ERR_CHR_BIG  = 3'd4;
  localparam logic [2:0] ERR_TRUNC    = 3'd5;
  localparam logic [2:0] ERR_TRAINER  = 3'd6;

  localparam logic [31:0] INES_MAGIC      = 32'h1A53454E;
  localparam int          PRG_CHUNK_BYTES = 16384;
  localparam int          CHR_CHUNK_BYTES = 8192;
  localparam int          TRAINER_BYTES   = 512;

  // One bit wider than the 22-bit byte counters so capacity compares never wrap.
  function automatic logic [22:0] size_bytes(input logic [7:0] count, input int unsigned chunk);
    return 23'(count) * 23'(chunk);
  endfunction

  function automatic logic is_receiving(input ines_ld_state_t st);
    return (st == ST_HDR) || (st == ST_TRAINER) || (st == ST_PRG) ||
           (st == ST_CHR) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/ines_stream_loader_packer.sv
// byte_word_packer: gathers four stream bytes into one 32-bit word (earliest
// byte in [7:0]) and issues a single-cycle write tagged with its target memory.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        valid,
  input  logic        sel,
  input  logic [7:0]  data,
  output logic        last_lane,
  output logic [31:0] word,
  output logic        wr,
  output logic        wr_sel
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic        wr_q, wr_d;
  logic        sel_q, sel_d;

  assign last_lane = (lane_q == 2'd3);

  // Lane counter, byte shifter and write strobe generation.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    word_d  = word_q;
    wr_d    = 1'b0;
    sel_d   = sel_q;
    if (clear) begin
      lane_d = 2'd0;
    end else if (valid) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {data, shift_q[23:8]};
      if (lane_q == 2'd3) begin
        word_d = {data, shift_q};
        wr_d   = 1'b1;
        sel_d  = sel;
      end else begin
        word_d = word_q;
      end
    end else begin
      lane_d = lane_q;
    end
  end

  // Packer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
      word_q  <= 32'd0;
      wr_q    <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
    end
  end

  assign word   = word_q;
  assign wr     = wr_q;
  assign wr_sel = sel_q;

endmodule

// File: rtl/ines_stream_loader.sv
// iNES stream loader: parses the header and writes PRG/CHR payload into the
// cartridge BRAMs. Optional trainer skipping: define INES_LOADER_TRAINER_EN.
module ines_stream_loader #(
  parameter int PRG_WIDTH = 17,
  parameter int CHR_WIDTH = 15
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 load_start,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [PRG_WIDTH-1:0] prg_addr,
  output logic [31:0]          prg_wr,
  output logic                 prg_en,
  output logic [3:0]           prg_we,
  output logic [CHR_WIDTH-1:0] chr_addr,
  output logic [31:0]          chr_wr,
  output logic                 chr_en,
  output logic [3:0]           chr_we,
  output logic [63:0]          ines_header,
  output logic                 nes_reset,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           error
);
  import nes_cart_pkg::*;

  localparam logic [22:0] PRG_CAP = 23'd1 << PRG_WIDTH;
  localparam logic [22:0] CHR_CAP = 23'd1 << CHR_WIDTH;

  ines_ld_state_t       state_q, state_d, after_hdr_s;
  logic [21:0]          cnt_q, cnt_d;
  logic [63:0]          shadow_q, shadow_d, header_q, header_d;
  logic [2:0]           err_q, err_d;
  logic                 done_q, done_d, nres_q, nres_d, rdy_q, rdy_d;
  logic [PRG_WIDTH-1:0] prg_addr_q, prg_addr_d, prg_next_q, prg_next_d;
  logic [CHR_WIDTH-1:0] chr_addr_q, chr_addr_d, chr_next_q, chr_next_d;
  logic                 accept_s, start_ok_s, pk_valid_s, pk_sel_s, pk_last_lane_s;
  logic                 pk_wr_s, pk_wr_sel_s, trainer_fault_s, prg_last_s, chr_last_s;
  logic [31:0]          pk_word_s;
  logic [7:0]           magic_byte_s;
  logic [22:0]          hdr_prg_s, hdr_chr_s, prg_size_s, chr_size_s;

  assign accept_s     = s_axis_tvalid & rdy_q;
  assign start_ok_s   = load_start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));
  assign pk_valid_s   = accept_s & ((state_q == ST_PRG) | (state_q == ST_CHR));
  assign pk_sel_s     = (state_q == ST_CHR);
  assign magic_byte_s = INES_MAGIC[{cnt_q[1:0], 3'b000} +: 8];
  assign hdr_prg_s    = size_bytes(shadow_q[7:0], PRG_CHUNK_BYTES);
  assign hdr_chr_s    = size_bytes(shadow_q[15:8], CHR_CHUNK_BYTES);
  assign prg_size_s   = size_bytes(header_q[7:0], PRG_CHUNK_BYTES);
  assign chr_size_s   = size_bytes(header_q[15:8], CHR_CHUNK_BYTES);
  assign prg_last_s   = ({1'b0, cnt_q} == (prg_size_s - 23'd1));
  assign chr_last_s   = ({1'b0, cnt_q} == (chr_size_s - 23'd1));

  // flags6[2] sits at shadow bit 18 once the header has been shifted in.
`ifdef INES_LOADER_TRAINER_EN
  assign trainer_fault_s = 1'b0;
  assign after_hdr_s     = shadow_q[18] ? ST_TRAINER : ST_PRG;
`else
  assign trainer_fault_s = shadow_q[18];
  assign after_hdr_s     = ST_PRG;
`endif

  byte_word_packer u_packer (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .clear     (start_ok_s),
    .valid     (pk_valid_s),
    .sel       (pk_sel_s),
    .data      (s_axis_tdata),
    .last_lane (pk_last_lane_s),
    .word      (pk_word_s),
    .wr        (pk_wr_s),
    .wr_sel    (pk_wr_sel_s)
  );

  // Load sequencing, header checks and write-address bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    header_d   = header_q;
    err_d      = err_q;
    done_d     = done_q;
    prg_addr_d = prg_addr_q;
    prg_next_d = prg_next_q;
    chr_addr_d = chr_addr_q;
    chr_next_d = chr_next_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          state_d    = ST_HDR;
          cnt_d      = 22'd0;
          err_d      = ERR_NONE;
          done_d     = 1'b0;
          prg_addr_d = '0;
          prg_next_d = '0;
          chr_addr_d = '0;
          chr_next_d = '0;
        end else begin
          done_d = (state_q == ST_DONE);
        end
      end
      ST_HDR: begin
        if (accept_s) begin
          cnt_d = cnt_q + 22'd1;
          if ((cnt_q[3:2] == 2'b01) || (cnt_q[3:2] == 2'b10)) begin
            shadow_d = {s_axis_tdata, shadow_q[63:8]};
          end else begin
            shadow_d = shadow_q;
          end
          if ((cnt_q[3:2] == 2'b00) && (s_axis_tdata != magic_byte_s)) begin
            state_d = ST_ERR; err_d = ERR_MAGIC;
          end else if (s_axis_tlast) begin
            state_d = ST_ERR; err_d = ERR_TRUNC;
          end else if (cnt_q[3:0] == 4'd15) begin
            if (hdr_prg_s == 23'd0) begin
              state_d = ST_ERR; err_d = ERR_PRG_ZERO;
            end else if (hdr_prg_s > PRG_CAP) begin
              state_d = ST_ERR; err_d = ERR_PRG_BIG;
            end else if (hdr_chr_s > CHR_CAP) begin
              state_d = ST_ERR; err_d = ERR_CHR_BIG;
            end else if (trainer_fault_s) begin
              state_d = ST_ERR; err_d = ERR_TRAINER;
            end else begin
              header_d = shadow_q;
              cnt_d    = 22'd0;
              state_d  = after_hdr_s;
            end
          end else begin
            state_d = ST_HDR;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
`ifdef INES_LOADER_TRAINER_EN
      ST_TRAINER: begin
        if (accept_s) begin
          cnt_d = cnt_q + 22'd1;
          if (s_axis_tlast) begin
            state_d = ST_ERR; err_d = ERR_TRUNC;
          end else if (cnt_q == 22'(TRAINER_BYTES - 1)) begin
            state_d = ST_PRG; cnt_d = 22'd0;
          end else begin
            state_d = ST_TRAINER;
          end
        end else begin
          state_d = ST_TRAINER;
        end
      end
`endif
      ST_PRG: begin
        if (accept_s) begin
          cnt_d = cnt_q + 22'd1;
          if (prg_last_s) begin
            cnt_d = 22'd0;
            if (chr_size_s == 23'd0) begin
              state_d = s_axis_tlast ? ST_DONE : ST_DRAIN;
            end else if (s_axis_tlast) begin
              state_d = ST_ERR; err_d = ERR_TRUNC;
            end else begin
              state_d = ST_CHR;
            end
          end else if (s_axis_tlast) begin
            state_d = ST_ERR; err_d = ERR_TRUNC;
          end else begin
            state_d = ST_PRG;
          end
        end else begin
          state_d = ST_PRG;
        end
      end
      ST_CHR: begin
        if (accept_s) begin
          cnt_d = cnt_q + 22'd1;
          if (chr_last_s) begin
            cnt_d   = 22'd0;
            state_d = s_axis_tlast ? ST_DONE : ST_DRAIN;
          end else if (s_axis_tlast) begin
            state_d = ST_ERR; err_d = ERR_TRUNC;
          end else begin
            state_d = ST_CHR;
          end
        end else begin
          state_d = ST_CHR;
        end
      end
      ST_DRAIN: begin
        if (accept_s && s_axis_tlast) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (pk_valid_s && pk_last_lane_s) begin
      if (pk_sel_s) begin
        chr_addr_d = chr_next_q;
        chr_next_d = chr_next_q + CHR_WIDTH'(4);
      end else begin
        prg_addr_d = prg_next_q;
        prg_next_d = prg_next_q + PRG_WIDTH'(4);
      end
    end else begin
      prg_next_d = prg_next_d;
    end
  end

  assign rdy_d  = is_receiving(state_d);
  assign nres_d = ~done_d;

  // Loader state and registered outputs.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 22'd0;
      shadow_q   <= 64'd0;
      header_q   <= 64'd0;
      err_q      <= ERR_NONE;
      done_q     <= 1'b0;
      nres_q     <= 1'b1;
      rdy_q      <= 1'b0;
      prg_addr_q <= '0;
      prg_next_q <= '0;
      chr_addr_q <= '0;
      chr_next_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      header_q   <= header_d;
      err_q      <= err_d;
      done_q     <= done_d;
      nres_q     <= nres_d;
      rdy_q      <= rdy_d;
      prg_addr_q <= prg_addr_d;
      prg_next_q <= prg_next_d;
      chr_addr_q <= chr_addr_d;
      chr_next_q <= chr_next_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign busy          = rdy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign nes_reset     = nres_q;
  assign ines_header   = header_q;
  assign prg_addr      = prg_addr_q;
  assign chr_addr      = chr_addr_q;
  assign prg_wr        = pk_word_s;
  assign chr_wr        = pk_word_s;
  assign prg_en        = pk_wr_s & ~pk_wr_sel_s;
  assign chr_en        = pk_wr_s & pk_wr_sel_s;
  assign prg_we        = {4{prg_en}};
  assign chr_we        = {4{chr_en}};

endmodule

// File: tb/tb_ines_stream_loader.sv
// Directed bench for ines_stream_loader: full image, header faults, truncation,
// trainer handling (INES_LOADER_TRAINER_EN) and reset mid-load.
module tb_ines_stream_loader;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [16:0] prg_addr;
  logic [31:0] prg_wr;
  logic        prg_en;
  logic [3:0]  prg_we;
  logic [14:0] chr_addr;
  logic [31:0] chr_wr;
  logic        chr_en;
  logic [3:0]  chr_we;
  logic [63:0] ines_header;
  logic        nes_reset, busy, done;
  logic [2:0]  error;

  int tests = 0;
  int fails = 0;
  logic [7:0] hdr [0:15];

  logic        mon_clr = 1'b0;
  int          prg_cnt, chr_cnt;
  logic [16:0] prg_first_addr, prg_last_addr;
  logic [14:0] chr_last_addr;
  logic [31:0] prg_first_word, prg_last_word, chr_first_word;
  logic        we_bad;

  ines_stream_loader #(.PRG_WIDTH(17), .CHR_WIDTH(15)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn), .load_start(load_start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .prg_addr(prg_addr), .prg_wr(prg_wr), .prg_en(prg_en), .prg_we(prg_we),
    .chr_addr(chr_addr), .chr_wr(chr_wr), .chr_en(chr_en), .chr_we(chr_we),
    .ines_header(ines_header), .nes_reset(nes_reset), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor: counts BRAM strobes and records first/last address and data.
  always @(posedge clk) begin
    if (mon_clr) begin
      prg_cnt <= 0;
      chr_cnt <= 0;
      we_bad  <= 1'b0;
    end else begin
      if ((prg_we !== {4{prg_en}}) || (chr_we !== {4{chr_en}})) we_bad <= 1'b1;
      if (prg_en) begin
        prg_cnt       <= prg_cnt + 1;
        prg_last_addr <= prg_addr;
        prg_last_word <= prg_wr;
        if (prg_cnt == 0) begin
          prg_first_addr <= prg_addr;
          prg_first_word <= prg_wr;
        end
      end
      if (chr_en) begin
        chr_cnt       <= chr_cnt + 1;
        chr_last_addr <= chr_addr;
        if (chr_cnt == 0) chr_first_word <= chr_wr;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_hdr(input logic [7:0] b0, input logic [7:0] b4, input logic [7:0] b5,
                         input logic [7:0] f6, input logic [7:0] f7);
    for (int i = 0; i < 16; i++) hdr[i] = 8'h00;
    hdr[0] = b0; hdr[1] = 8'h45; hdr[2] = 8'h53; hdr[3] = 8'h1A;
    hdr[4] = b4; hdr[5] = b5; hdr[6] = f6; hdr[7] = f7;
  endtask

  // Payload byte at offset q from the start of PRG data is q[7:0] ^ q[15:8].
  function automatic logic [7:0] file_byte(input int p, input bit trn);
    logic [31:0] q;
    if (p < 16) return hdr[p];
    q = 32'(p - 16);
    if (trn) begin
      if (q < 32'd512) return 8'hEE;
      q = q - 32'd512;
    end
    return q[7:0] ^ q[15:8];
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last, output bit acc);
    @(negedge clk);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    acc = s_axis_tready;
    @(posedge clk);
  endtask

  task automatic send_stream(input int p0, input int n, input int tlast_pos, input bit trn);
    bit acc;
    for (int p = p0; p < n; p++) begin
      send_byte(file_byte(p, trn), (p == tlast_pos), acc);
      if (!acc) break;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    clear_mon();
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_nes_reset", nes_reset, 1'b1);
    check("rst_error", error, 3'd0);
    check("rst_header", ines_header, 64'd0);
    check("rst_prg_en", {prg_en, chr_en}, 2'b00);
    check("rst_addr_data", {prg_addr, chr_addr, prg_wr}, 64'd0);

    // Full image: 2 PRG chunks, 1 CHR chunk, mapper 1, tlast on last byte.
    set_hdr(8'h4E, 8'h02, 8'h01, 8'h10, 8'h00);
    pulse_start();
    check("start_busy", {busy, s_axis_tready, nes_reset, done}, 4'b1110);
    send_stream(0, 16 + 32768 + 8192, 16 + 32768 + 8192 - 1, 1'b0);
    repeat (4) @(negedge clk);
    check("img_prg_cnt", prg_cnt, 8192);
    check("img_prg_last_addr", prg_last_addr, 17'h07FFC);
    check("img_prg_first_word", prg_first_word, 32'h03020100);
    check("img_prg_last_word", prg_last_word, 32'h80818283);
    check("img_chr_cnt", chr_cnt, 2048);
    check("img_chr_last_addr", chr_last_addr, 15'h1FFC);
    check("img_chr_first_word", chr_first_word, 32'h83828180);
    check("img_header", ines_header[31:0], 32'h00100102);
    check("img_done_nres_err", {done, nes_reset, error}, 5'b10000);
    check("img_idle", {busy, s_axis_tready}, 2'b00);
    check("img_we", we_bad, 1'b0);

    // Bad first magic byte.
    clear_mon();
    set_hdr(8'h4F, 8'h02, 8'h01, 8'h00, 8'h00);
    pulse_start();
    send_stream(0, 16, -1, 1'b0);
    check("magic_err", {error, s_axis_tready, nes_reset, done}, {3'd1, 3'b010});
    check("magic_writes", prg_cnt + chr_cnt, 0);

    // PRG count 16 exceeds 128 KiB.
    set_hdr(8'h4E, 8'd16, 8'h00, 8'h00, 8'h00);
    pulse_start();
    send_stream(0, 16, -1, 1'b0);
    check("prg_big_err", {error, s_axis_tready}, {3'd3, 1'b0});
    check("prg_big_writes", prg_cnt, 0);

    // PRG count zero.
    set_hdr(8'h4E, 8'h00, 8'h01, 8'h00, 8'h00);
    pulse_start();
    send_stream(0, 16, -1, 1'b0);
    check("prg_zero_err", error, 3'd2);

    // CHR count 5 (40 KiB) exceeds 32 KiB.
    set_hdr(8'h4E, 8'h01, 8'h05, 8'h00, 8'h00);
    pulse_start();
    send_stream(0, 16, -1, 1'b0);
    check("chr_big_err", error, 3'd4);

    // Exactly at capacity on both memories is accepted.
    set_hdr(8'h4E, 8'h08, 8'h04, 8'h00, 8'h00);
    pulse_start();
    send_stream(0, 16, -1, 1'b0);
    check("cap_edge_ok", {error, busy}, {3'd0, 1'b1});
    pulse_reset();

    // tlast on PRG byte 100.
    clear_mon();
    set_hdr(8'h4E, 8'h01, 8'h00, 8'h00, 8'h00);
    pulse_start();
    send_stream(0, 16 + 200, 16 + 99, 1'b0);
    repeat (2) @(negedge clk);
    check("trunc_err", {error, s_axis_tready, nes_reset}, {3'd5, 2'b01});
    check("trunc_cnt", prg_cnt, 25);
    check("trunc_last_addr", prg_last_addr, 17'h00060);

    // Trainer flag set.
    clear_mon();
    set_hdr(8'h4E, 8'h01, 8'h00, 8'h04, 8'h00);
    pulse_start();
`ifdef INES_LOADER_TRAINER_EN
    send_stream(0, 16 + 512 + 4, -1, 1'b1);
    repeat (2) @(negedge clk);
    check("trainer_cnt", prg_cnt, 1);
    check("trainer_first_word", prg_first_word, 32'h03020100);
    pulse_reset();
`else
    send_stream(0, 16, -1, 1'b1);
    check("trainer_err", error, 3'd6);
    check("trainer_writes", prg_cnt, 0);
`endif

    // Reset mid-PRG with an ignored load_start, then a clean load ending in DRAIN.
    clear_mon();
    set_hdr(8'h4E, 8'h01, 8'h00, 8'h00, 8'h00);
    pulse_start();
    send_stream(0, 46, -1, 1'b0);
    pulse_start();
    send_stream(46, 66, -1, 1'b0);
    check("busy_start_ignored", {error, busy}, {3'd0, 1'b1});
    pulse_reset();
    repeat (2) @(negedge clk);
    check("midrst_state", {s_axis_tready, busy, nes_reset, done, error}, {4'b0010, 3'd0});
    check("midrst_writes", prg_cnt, 12);
    clear_mon();
    pulse_start();
    send_stream(0, 16 + 16384 + 3, 16 + 16384 + 2, 1'b0);
    repeat (2) @(negedge clk);
    check("reload_first_addr", prg_first_addr, 17'h00000);
    check("reload_cnt", prg_cnt, 4096);
    check("reload_last_addr", prg_last_addr, 17'h03FFC);
    check("reload_chr_cnt", chr_cnt, 0);
    check("reload_done", {done, nes_reset, error}, {2'b10, 3'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ines_stream_loader.md
# ines_stream_loader

Loads an iNES image from a byte stream into the cartridge memories on the AXI side of the cartridge, ahead of the multimapper cartridge. It parses the 16-byte iNES header and publishes header bytes 4..11 as `ines_header`. It packs PRG and CHR payload bytes into 32-bit words on the cartridge BRAM write ports, and holds `nes_reset` asserted for the whole load.

## Interface
- PRG_WIDTH, 17: PRG ROM byte-address width; capacity is 2^PRG_WIDTH bytes.
- CHR_WIDTH, 15: CHR ROM byte-address width; capacity is 2^CHR_WIDTH bytes.
- S_AXI_ACLK  in  1  sole clock; all logic on the rising edge.
- S_AXI_ARESETN  in  1  reset; synchronous, active-low.
- load_start  in  1  single-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERR.
- s_axis_tdata  in  8  image byte, in file order.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when tvalid && tready.
- s_axis_tlast  in  1  marks the final byte of the file.
- prg_addr  out  PRG_WIDTH  byte address of the word; bits [1:0] always 0.
- prg_wr  out  32  packed word; the earliest byte goes in [7:0].
- prg_en  out  1  write strobe.
- prg_we  out  4  byte-lane enables; 4'hF when prg_en is high, else 0.
- chr_addr, chr_wr, chr_en, chr_we  out  CHR_WIDTH/32/1/4  same rules as the prg_* outputs, for CHR.
- ines_header  out  64  header bytes 4..11; byte 4 goes in [7:0].
- nes_reset  out  1  high while a load is in progress.
- busy  out  1  high in any receiving state.
- done  out  1  level signal; image loaded successfully.
- error  out  3  error code: 0 none, 1 bad magic, 2 PRG count is zero, 3 PRG too large, 4 CHR too large, 5 truncated, 6 trainer not supported.

## Operation
- States:
  - IDLE → (load_start) HDR
  - HDR (16 bytes) → TRAINER if flags6[2] is set, else PRG
  - TRAINER (512 bytes, discarded) → PRG
  - PRG → CHR, or → DRAIN if the CHR count is 0
  - CHR → DRAIN
  - DRAIN discards bytes until tlast, then → DONE
  - any receiving state → ERR on a fault
  - DONE or ERR → (load_start) HDR
- HDR:
  - Bytes 0..3 must equal 4E 45 53 1A; a mismatch latches error=1.
  - Bytes 4..11 shift into a shadow register. `ines_header` updates from the shadow only on the HDR→next transition.
  - Bytes 12..15 are ignored.
- Size checks, on the 16th header byte:
  - prg = byte4 × 16384; prg == 0 gives error 2.
  - prg > 2^PRG_WIDTH gives error 3.
  - chr = byte5 × 8192 > 2^CHR_WIDTH gives error 4.
  - Byte counters are 22 bits wide; comparisons are made at full width, with no truncation.
- PRG/CHR payload:
  - A 2-bit lane counter packs bytes into a word.
  - When the fourth byte is accepted, the word is registered and a single-cycle write is issued.
  - The address starts at 0 and increments by 4 after each write.
  - Sizes are multiples of 4, so no partial word exists.
- tlast:
  - tlast accepted before the last PRG or CHR byte gives error 5.
  - tlast accepted in HDR or TRAINER gives error 5.
  - tlast on the final payload byte goes directly to DONE, without passing through DRAIN.
- tready is 1 in HDR, TRAINER, PRG, CHR and DRAIN, and 0 in IDLE, DONE and ERR.
- ERR:
  - `error` holds its code.
  - `nes_reset` stays high.
  - No further BRAM writes are issued.
  - Stream bytes are not consumed.
- load_start clears `error` and `done`, and zeroes the address counters.

## Timing
- Reset values:
  - tready, prg_en, chr_en, busy and done are 0; all write data and addresses are 0.
  - ines_header is 0.
  - nes_reset is 1 (the NES stays held until a successful load).
  - error is 0.
  - State is IDLE.
- Throughput is one byte per cycle with no stalls. A BRAM write is issued the cycle after its 4th byte is accepted (1-cycle latency).
- `done` rises one cycle after the final write, or one cycle after tlast is accepted in DRAIN. `nes_reset` falls in the same cycle that `done` rises.
- `ines_header` is stable from the end of HDR until the next load_start.
- Reset mid-load aborts the load: state returns to IDLE, no write is issued for a partially packed word, and nes_reset=1.
- A load_start arriving while busy is ignored.

## Configuration
- INES_LOADER_TRAINER_EN:
  - Defined: the TRAINER state exists, and 512 bytes are skipped when flags6[2] is set.
  - Undefined: flags6[2]=1 on the 16th header byte gives error 6, and the TRAINER state is not synthesised.

## Structure
- The shared package `nes_cart_pkg` holds:
  - the state enum `ines_ld_state_t`;
  - the error-code constants;
  - INES_MAGIC (32'h1A53454E);
  - PRG_CHUNK_BYTES (16384) and CHR_CHUNK_BYTES (8192).
- One sub-module, `byte_word_packer`, built from the lane counter, shift register and write strobe. It is instantiated once and steered to PRG or CHR by state.

## Test plan
- Image with 2 PRG chunks, 1 CHR chunk, mapper 1, and tlast on the last byte:
  - prg_en pulses 8192 times, with the final prg_addr = 0x7FFC;
  - chr_en pulses 2048 times;
  - ines_header[31:0] = {flags7, flags6, 01, 02};
  - done=1 and nes_reset=0.
- First byte 0x4F → error=1, tready=0, no writes, nes_reset=1.
- Header with byte4=4 and PRG_WIDTH=17 (64 KiB > 128 KiB? no). Use byte4=16 → error=3 on the 16th byte, no writes.
- tlast on PRG byte 100 → error=5; the last write seen is at prg_addr 0x60.
- Trainer bit set:
  - with the macro defined, the first PRG word equals bytes 528..531;
  - with the macro undefined, error=6.
- S_AXI_ARESETN low for 1 cycle mid-PRG, then load_start plus a valid image → writes restart at address 0, and done=1.
